// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS control sequencer
package mc_pkg;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_EXE = 4'd2,
    S_AWB = 4'd3,
    S_MA  = 4'd4,
    S_MR  = 4'd5,
    S_MW  = 4'd6,
    S_LWB = 4'd7,
    S_BR  = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_SLT = 3'b101,
    ALU_LUI = 3'b110
  } alu_op_t;

  typedef enum logic [3:0] {
    IC_ILL, IC_RTYPE, IC_ADDI, IC_ORI, IC_LUI, IC_LW, IC_SW, IC_BEQ, IC_J
  } iclass_t;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - shared instruction/data memory port of the sequencer
interface mc_ctrl_if;
  logic mem_req;
  logic mem_ready;
  logic IorD;
  logic MemWrite;

  modport master (output mem_req, IorD, MemWrite, input mem_ready);
  modport slave  (input mem_req, IorD, MemWrite, output mem_ready);
endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - Op/Funct to instruction class and execute-stage ALU control
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output alu_op_t    alu_op,
  output logic       ext_op
);

  always_comb begin
    iclass = IC_ILL;
    alu_op = ALU_NOP;
    ext_op = 1'b0;
    case (op)
      OP_RTYPE: begin
        iclass = IC_RTYPE;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: iclass = IC_ILL;
        endcase
      end
      OP_ADDI: begin iclass = IC_ADDI; alu_op = ALU_ADD; ext_op = 1'b1; end
      OP_ORI:  begin iclass = IC_ORI;  alu_op = ALU_OR;  end
      OP_LUI:  begin iclass = IC_LUI;  alu_op = ALU_LUI; end
      OP_LW:   begin iclass = IC_LW;   alu_op = ALU_ADD; ext_op = 1'b1; end
      OP_SW:   begin iclass = IC_SW;   alu_op = ALU_ADD; ext_op = 1'b1; end
      OP_BEQ:  begin iclass = IC_BEQ;  alu_op = ALU_SUB; ext_op = 1'b1; end
      OP_J:    iclass = IC_J;
      default: iclass = IC_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle control FSM driving the MIPS datapath strobes
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  mc_ctrl_if.master        mem,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       NPCOp,
  output logic             RegWrite,
  output logic             EXTOp,
  output logic [2:0]       ALUOp,
  output logic             ALUSrc,
  output logic             GPRSel,
  output logic             WDSel,
  output logic             illegal,
  output logic             mem_err,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state_o
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  state_t           state, state_nxt;
  logic [WW-1:0]    wait_cnt;
  logic [CNT_W-1:0] cnt;
  logic             wait_lim;
  iclass_t          iclass;
  alu_op_t          dec_alu;
  logic             dec_ext;

  mc_decode u_decode (
    .op     (Op),
    .funct  (Funct),
    .iclass (iclass),
    .alu_op (dec_alu),
    .ext_op (dec_ext)
  );

  // This cycle is the last unanswered one allowed; a same-cycle mem_ready still completes.
  assign wait_lim = (wait_cnt == WW'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IF;
      wait_cnt <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt + CNT_W'(retire);
      if (state_nxt != state || mem_err)
        wait_cnt <= '0;
      else if (mem.mem_req && !mem.mem_ready)
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    mem.mem_req  = 1'b0;
    mem.IorD     = 1'b0;
    mem.MemWrite = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    NPCOp        = NPC_PC4;
    RegWrite     = 1'b0;
    EXTOp        = 1'b0;
    ALUOp        = ALU_NOP;
    ALUSrc       = 1'b0;
    GPRSel       = 1'b0;
    WDSel        = 1'b0;
    illegal      = 1'b0;
    mem_err      = 1'b0;
    retire       = 1'b0;
    case (state)
      S_IF: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          state_nxt = S_ID;
        end else if (wait_lim) begin
          mem_err = 1'b1;
        end
      end
      S_ID: begin
        case (iclass)
          IC_RTYPE, IC_ADDI, IC_ORI, IC_LUI: state_nxt = S_EXE;
          IC_LW, IC_SW:                      state_nxt = S_MA;
          IC_BEQ:                            state_nxt = S_BR;
          IC_J: begin
            PCWrite   = 1'b1;
            NPCOp     = NPC_J;
            retire    = 1'b1;
            state_nxt = S_IF;
          end
          default: begin
            illegal   = 1'b1;
            state_nxt = S_IF;
          end
        endcase
      end
      S_EXE: begin
        ALUOp     = dec_alu;
        ALUSrc    = (iclass != IC_RTYPE);
        EXTOp     = dec_ext;
        state_nxt = S_AWB;
      end
      S_AWB: begin
        RegWrite  = 1'b1;
        GPRSel    = (iclass != IC_RTYPE);
        retire    = 1'b1;
        state_nxt = S_IF;
      end
      S_MA: begin
        ALUOp     = ALU_ADD;
        ALUSrc    = 1'b1;
        EXTOp     = 1'b1;
        state_nxt = (iclass == IC_LW) ? S_MR : S_MW;
      end
      S_MR: begin
        mem.mem_req = 1'b1;
        mem.IorD    = 1'b1;
        if (mem.mem_ready) begin
          state_nxt = S_LWB;
        end else if (wait_lim) begin
          mem_err   = 1'b1;
          state_nxt = S_IF;
        end
      end
      S_LWB: begin
        RegWrite  = 1'b1;
        WDSel     = 1'b1;
        GPRSel    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_IF;
      end
      S_MW: begin
        mem.mem_req  = 1'b1;
        mem.IorD     = 1'b1;
        mem.MemWrite = 1'b1;
        if (mem.mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_IF;
        end else if (wait_lim) begin
          mem_err   = 1'b1;
          state_nxt = S_IF;
        end
      end
      S_BR: begin
        ALUOp     = ALU_SUB;
        EXTOp     = 1'b1;
        retire    = 1'b1;
        state_nxt = S_IF;
        if (Zero) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_BR;
        end
      end
      default: state_nxt = S_IF;
    endcase
    // Nothing may strobe the datapath while reset is held, even though S_IF requests memory.
    if (!rst) begin
      mem.mem_req  = 1'b0;
      mem.IorD     = 1'b0;
      mem.MemWrite = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      NPCOp        = NPC_PC4;
      RegWrite     = 1'b0;
      EXTOp        = 1'b0;
      ALUOp        = ALU_NOP;
      ALUSrc       = 1'b0;
      GPRSel       = 1'b0;
      WDSel        = 1'b0;
      illegal      = 1'b0;
      mem_err      = 1'b0;
      retire       = 1'b0;
    end
  end

  assign instr_cnt = rst ? cnt : '0;
  assign state_o   = rst ? state : 4'd0;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against an instruction-level model
module tb_mc_ctrl;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 8;
  localparam int NI       = 12;

  typedef struct packed {
    logic [3:0] st;
    logic       req, iord, irw, pcw;
    logic [1:0] npc;
    logic       rw, mw, ext;
    logic [2:0] alu;
    logic       src, gpr, wd, ill, err, ret;
  } ov_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       Op, Funct;
  logic             Zero;
  logic             IRWrite, PCWrite, RegWrite, EXTOp, ALUSrc, GPRSel, WDSel;
  logic             illegal, mem_err, retire;
  logic [1:0]       NPCOp;
  logic [2:0]       ALUOp;
  logic [CNT_W-1:0] instr_cnt;
  logic [3:0]       state_o;

  mc_ctrl_if bus ();

  mc_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem(bus),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .NPCOp(NPCOp), .RegWrite(RegWrite),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .GPRSel(GPRSel), .WDSel(WDSel),
    .illegal(illegal), .mem_err(mem_err), .retire(retire),
    .instr_cnt(instr_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  ov_t obs;
  assign obs = {state_o, bus.mem_req, bus.IorD, IRWrite, PCWrite, NPCOp, RegWrite,
                bus.MemWrite, EXTOp, ALUOp, ALUSrc, GPRSel, WDSel, illegal, mem_err, retire};

  // Legal instruction table: kind 0=alu 1=lw 2=sw 3=beq 4=j
  int t_op  [NI] = '{'h00, 'h00, 'h00, 'h00, 'h00, 'h08, 'h0d, 'h0f, 'h23, 'h2b, 'h04, 'h02};
  int t_fn  [NI] = '{'h20, 'h22, 'h24, 'h25, 'h2a, 0, 0, 0, 0, 0, 0, 0};
  int t_kind[NI] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4};
  int t_alu [NI] = '{1, 2, 3, 4, 5, 1, 4, 6, 0, 0, 0, 0};
  int t_ext [NI] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

  int n_chk = 0, n_fail = 0;
  int exp_cnt = 0;
  int fetch_lat = -1, data_lat = -1, br_zero = -1;
  logic [5:0] cur_op, cur_fn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ov_t ev(input int s);
    ov_t e = '0;
    e.st = 4'(s);
    return e;
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic int pick_lat();
    int r = $urandom_range(0, 9);
    return (r < 7) ? r % 3 : 3 + r - 7;
  endfunction

  function automatic int lookup(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < NI; i++)
      if (op == 6'(t_op[i]) && (op != 6'h00 || fn == 6'(t_fn[i]))) return i;
    return -1;
  endfunction

  // One clock cycle: drive inputs mid-cycle, compare all strobes before the next rising edge.
  task automatic step(input ov_t e, input bit rdy, input bit z, input bit fetching, input string tag);
    @(negedge clk);
    Op            = fetching ? 6'($urandom) : cur_op;
    Funct         = fetching ? 6'($urandom) : cur_fn;
    Zero          = z;
    bus.mem_ready = rdy;
    #1;
    check(tag, 32'(obs), 32'(e));
    if (e.ret) exp_cnt++;
  endtask

  task automatic do_fetch();
    bit done = 0;
    while (!done) begin
      int lat = (fetch_lat >= 0) ? fetch_lat : pick_lat();
      fetch_lat = -1;
      for (int k = 0; k < WAIT_MAX; k++) begin
        ov_t e = ev(0);
        e.req = 1;
        if (k == lat) begin
          e.irw = 1; e.pcw = 1;
          step(e, 1, rb(), 1, "fetch_done");
          done = 1;
          break;
        end else if (k == WAIT_MAX - 1) begin
          e.err = 1;
          step(e, 0, rb(), 1, "fetch_timeout");
        end else begin
          step(e, 0, rb(), 1, "fetch_wait");
        end
      end
    end
  endtask

  task automatic do_data(input bit wr, output bit ok);
    int lat = (data_lat >= 0) ? data_lat : pick_lat();
    data_lat = -1;
    ok = 0;
    for (int k = 0; k < WAIT_MAX; k++) begin
      ov_t e = ev(wr ? 6 : 5);
      e.req = 1; e.iord = 1; e.mw = wr;
      if (k == lat) begin
        e.ret = wr;
        step(e, 1, rb(), 0, "mem_done");
        ok = 1;
        break;
      end else if (k == WAIT_MAX - 1) begin
        e.err = 1;
        step(e, 0, rb(), 0, "mem_timeout");
      end else begin
        step(e, 0, rb(), 0, "mem_wait");
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    int  idx = lookup(op, fn);
    ov_t e;
    bit  ok, z;
    cur_op = op;
    cur_fn = fn;
    do_fetch();
    e = ev(1);
    if (idx < 0) begin
      e.ill = 1;
      step(e, rb(), rb(), 0, "id_illegal");
    end else begin
      case (t_kind[idx])
        0: begin
          step(e, rb(), rb(), 0, "id");
          e = ev(2); e.alu = 3'(t_alu[idx]); e.src = (op != 6'h00); e.ext = 1'(t_ext[idx]);
          step(e, rb(), rb(), 0, "exe");
          e = ev(3); e.rw = 1; e.gpr = (op != 6'h00); e.ret = 1;
          step(e, rb(), rb(), 0, "awb");
        end
        1, 2: begin
          step(e, rb(), rb(), 0, "id");
          e = ev(4); e.alu = 3'd1; e.src = 1; e.ext = 1;
          step(e, rb(), rb(), 0, "ma");
          do_data(t_kind[idx] == 2, ok);
          if (ok && t_kind[idx] == 1) begin
            e = ev(7); e.rw = 1; e.wd = 1; e.gpr = 1; e.ret = 1;
            step(e, rb(), rb(), 0, "lwb");
          end
        end
        3: begin
          step(e, rb(), rb(), 0, "id");
          z = (br_zero >= 0) ? 1'(br_zero) : rb();
          br_zero = -1;
          e = ev(8); e.alu = 3'd2; e.ext = 1; e.ret = 1; e.pcw = z; e.npc = z ? 2'b01 : 2'b00;
          step(e, rb(), z, 0, "br");
        end
        default: begin
          e.pcw = 1; e.npc = 2'b10; e.ret = 1;
          step(e, rb(), rb(), 0, "id_jump");
        end
      endcase
    end
    @(posedge clk);
    #1;
    check("instr_cnt", 32'(instr_cnt), 32'(exp_cnt % (1 << CNT_W)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ov_t e;
    int  idx;
    logic [5:0] op, fn;
    rst = 1'b0; bus.mem_ready = 1'b1; Zero = 1'b1; Op = 6'h00; Funct = 6'h20;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 32'(obs), 32'h0);
    check("reset_cnt", 32'(instr_cnt), 32'h0);
    rst = 1'b1; bus.mem_ready = 1'b0;

    fetch_lat = 0; run_instr(6'h00, 6'h20);
    fetch_lat = 0; data_lat = 3; run_instr(6'h23, 6'h00);
    br_zero = 1; run_instr(6'h04, 6'h11);
    br_zero = 0; run_instr(6'h04, 6'h11);
    run_instr(6'h3f, 6'h20);
    run_instr(6'h00, 6'h3f);
    data_lat = 99; run_instr(6'h2b, 6'h00);
    fetch_lat = 99; run_instr(6'h08, 6'h00);
    run_instr(6'h02, 6'h00);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) != 0) begin
        idx = $urandom_range(0, NI - 1);
        op  = 6'(t_op[idx]);
        fn  = (op == 6'h00) ? 6'(t_fn[idx]) : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr(op, fn);
    end

    // Reset asserted between edges while a load waits in S_MR
    cur_op = 6'h23; cur_fn = 6'h00;
    fetch_lat = 0;
    do_fetch();
    step(ev(1), 0, 0, 0, "id");
    e = ev(4); e.alu = 3'd1; e.src = 1; e.ext = 1;
    step(e, 0, 0, 0, "ma");
    e = ev(5); e.req = 1; e.iord = 1;
    step(e, 0, 0, 0, "mr_wait");
    @(posedge clk);
    #2;
    rst = 1'b0; bus.mem_ready = 1'b1;
    #1;
    check("midreset_outputs", 32'(obs), 32'h0);
    check("midreset_cnt", 32'(instr_cnt), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1; bus.mem_ready = 1'b0;
    exp_cnt = 0;
    fetch_lat = 0; run_instr(6'h0d, 6'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS datapath: PC, NPC, RF, EXT, alu, the GPR/WD/ALU-B muxes, plus an instruction register (IR).
- Replaces the single-cycle combinational decoder.
- One memory port is shared between instruction fetch and data access, via a req/ready handshake.
- Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath strobe and mux select.

Parameters:
- WAIT_MAX, 255, maximum cycles mem_req may stay unanswered before the access is aborted.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Op  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  alu zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- IorD  out  1  memory address select: 0=PC, 1=aluout register.
- IRWrite  out  1  load IR from readdata.
- PCWrite  out  1  load PC from NPC.
- NPCOp  out  2  00=PC+4, 01=branch, 10=jump.
- RegWrite  out  1  RF write enable.
- MemWrite  out  1  memory write, valid only with mem_req.
- EXTOp  out  1  1=sign extend, 0=zero extend.
- ALUOp  out  3  alu operation code.
- ALUSrc  out  1  ALU B select: 0=RD2, 1=Imm32.
- GPRSel  out  1  A3 select: 0=rd, 1=rt.
- WDSel  out  1  WD select: 0=aluout, 1=readdata.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- mem_err  out  1  one-cycle pulse on a memory timeout.
- retire  out  1  one-cycle pulse when an instruction completes.
- instr_cnt  out  CNT_W  count of retired instructions.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset (rst=0, asynchronous): state=S_IF, wait counter=0, instr_cnt=0. While rst=0, every output is forced to 0.
- Outputs are combinational from the state register, Op, Funct, Zero and mem_ready. Op/Funct are read only from S_ID onward, when IR is stable.
- Default for every output in every state is 0 / PC+4 / ALU_NOP.
- S_IF:
  - mem_req=1, IorD=0.
  - On mem_ready: IRWrite=1, PCWrite=1 (NPCOp=00), go to S_ID.
- S_ID: decode.
  - R-type (add/sub/and/or/slt), addi, ori, lui -> S_EXE.
  - lw, sw -> S_MA.
  - beq -> S_BR.
  - j: PCWrite=1, NPCOp=10, retire=1, go to S_IF.
  - Anything else, including R-type with an unknown Funct: illegal=1, go to S_IF with no state change.
- S_EXE: drive ALUOp, ALUSrc and EXTOp for the instruction; go to S_AWB.
  - R-type: ALUSrc=0.
  - addi: ADD, EXTOp=1.
  - ori: OR, EXTOp=0.
  - lui: LUI, EXTOp=0.
- S_AWB: RegWrite=1, WDSel=0, GPRSel = R-type?0:1; retire=1; go to S_IF.
- S_MA: ALUOp=ADD, ALUSrc=1, EXTOp=1. lw -> S_MR, sw -> S_MW.
- S_MR: mem_req=1, IorD=1. On mem_ready -> S_LWB.
- S_LWB: RegWrite=1, WDSel=1, GPRSel=1, retire=1; go to S_IF.
- S_MW: mem_req=1, MemWrite=1, IorD=1. On mem_ready: retire=1, go to S_IF.
- S_BR: ALUOp=SUB, ALUSrc=0, EXTOp=1, retire=1; go to S_IF.
  - Zero=1: PCWrite=1, NPCOp=01.
  - Zero=0: no PC write (PC already holds PC+4).
- Wait counter:
  - Cleared on entry to any request state (S_IF, S_MR, S_MW); increments each cycle mem_req=1 and mem_ready=0.
  - Reaching WAIT_MAX: mem_err=1, go to S_IF, no write of any kind.
  - A fetch timeout refetches the same PC. A data timeout drops the instruction, which is not retired.
  - mem_ready in the same cycle the limit is reached: ready wins.
- instr_cnt increments on retire and wraps modulo 2^CNT_W.
- mem_ready outside a request state is ignored.
- Reset mid-access aborts immediately; no strobe follows reset release until S_IF.

Decomposition:
- Package mc_pkg:
  - State encoding: S_IF=0, S_ID=1, S_EXE=2, S_AWB=3, S_MA=4, S_MR=5, S_MW=6, S_LWB=7, S_BR=8.
  - ALUOp: NOP=000, ADD=001, SUB=010, AND=011, OR=100, SLT=101, LUI=110.
  - NPCOp codes.
  - Opcodes: RTYPE=000000, ADDI=001000, ORI=001101, LUI=001111, LW=100011, SW=101011, BEQ=000100, J=000010.
  - Funct codes: ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010.
- Sub-module mc_decode: combinational Op/Funct -> instruction class and ALUOp. The FSM stays in mc_ctrl.

Test Plan:
- Reset release, mem_ready tied to 1: expect state sequence IF,ID,EXE,AWB for add (Op=0, Funct=100000). RegWrite=1 only in AWB with GPRSel=0; instr_cnt=1 after 4 cycles.
- lw (Op=100011), mem_ready delayed 3 cycles in S_MR: mem_req is held 4 cycles, then LWB with WDSel=1, GPRSel=1; total 8 cycles, retire once.
- beq: Zero=1 gives PCWrite=1, NPCOp=01 in S_BR. Zero=0 gives PCWrite=0; retire=1 in both cases.
- Op=111111 in S_ID: illegal pulse for 1 cycle, return to IF, RegWrite/MemWrite never asserted, instr_cnt unchanged.
- WAIT_MAX=4, mem_ready=0 during sw: mem_err pulses after 4 wait cycles, MemWrite drops, state returns to IF, no retire.
- rst driven low mid-S_MR (asynchronously, between edges): all outputs 0 immediately; after release, state=S_IF and instr_cnt=0.
